ni_inject_fifo: RTL and testbench
=================================

// Module: ni_inject_fifo
// PURPOSE
//  Network-interface injection queue between a 20-bit flit source (ROM streamer, valid-only, no backpressure)
//  and a router local input port (valid/ready). Absorbs source bursts, discards null flits (20'h00000),
//  presents flits first-word-fall-through to the router. Flags overflow because the source cannot be stalled.
// PARAMETERS
//  DW     20  flit width in bits
//  DEPTH  8   queue entries; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (derived; do not override)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst        in   1      asynchronous, active-low reset
//  in_data    in   DW     flit from source
//  in_valid   in   1      in_data valid this cycle; no ready back to source
//  out_data   out  DW     head flit (valid only when out_valid=1)
//  out_valid  out  1      queue non-empty
//  out_ready  in   1      router accepts head flit this cycle
//  count      out  AW+1   occupancy, 0..DEPTH
//  full       out  1      count==DEPTH
//  overflow   out  1      sticky: a non-null flit was dropped because queue full
// BEHAVIOUR
//  - Reset (rst=0, async): rd/wr pointers=0, count=0, out_valid=0, full=0, overflow=0; mem contents don't-care.
//  - push = in_valid && (in_data != 0) && (!full || pop); pop = out_valid && out_ready.
//  - Null flit (in_data==0) with in_valid=1: ignored, no state change, never counted as overflow.
//  - Push writes mem[wr_ptr], wr_ptr+1 (wraps modulo DEPTH). Pop: rd_ptr+1 (wraps modulo DEPTH).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Latency: flit pushed at edge N appears on out_data/out_valid after edge N (1 cycle), if queue was empty.
//  - FWFT: out_data = mem[rd_ptr] combinationally; out_valid = (count!=0); out_data held stable while out_valid && !out_ready.
//  - Full + push + pop same cycle: both happen, count stays DEPTH, no overflow.
//  - Full + push, no pop: flit dropped, overflow<=1 (stays 1 until reset).
//  - Empty + push + out_ready: no bypass; flit lands, visible next cycle.
//  - out_ready while empty: no effect. Source stream order preserved exactly (minus nulls/drops).
//  - Reset mid-stream: queued flits discarded; resumes cleanly on first valid after rst release.
// CONFIGURATION
//  NI_INJ_STATS_EN defined: extra outputs acc_cnt[15:0] (flits pushed) and drop_cnt[15:0] (non-null flits
//   dropped on full); both saturate at 16'hFFFF, reset to 0. Null flits counted by neither.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package noc_pkg: FLIT_W=20, NULL_FLIT=20'h00000, flit field localparams (src/dst nibbles [19:16]/[15:12]).
//  One sub-module natural: ni_fifo_mem (DEPTH x DW register array, 1 write port, 1 async read port).
//  Control (pointers, count, flags, stats) stays in ni_inject_fifo.
// TESTING
//  1 Reset: rst=0 with in_valid=1 -> count=0, out_valid=0, overflow=0; after release, 1st flit 20'h30010 out 1 cycle later.
//  2 Null filter: stream 20'h00000,20'h30010,20'h00000,20'h30020 with out_ready=0 -> count=2, head=20'h30010.
//  3 Overflow: DEPTH=8, out_ready=0, push 9 non-null flits -> count=8, full=1, overflow=1; 9th flit never appears on out.
//  4 Full simultaneous: full, out_ready=1, push 20'h33423 -> count stays 8, overflow unchanged, 20'h33423 last out.
//  5 Backpressure/order: push 20'h31011,20'h31021,20'h32012, toggle out_ready 1010.. -> output order identical, data stable while stalled.
//  6 Wrap: push/pop 3*DEPTH flits continuously at out_ready=1 -> count<=1 throughout, all flits in order; NI_INJ_STATS_EN acc_cnt=24, drop_cnt=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, the null flit value and flit header field positions.
package noc_pkg;

  localparam int FLIT_W = 20;
  localparam logic [FLIT_W-1:0] NULL_FLIT = 20'h00000;

  localparam int SRC_MSB = 19;
  localparam int SRC_LSB = 16;
  localparam int DST_MSB = 15;
  localparam int DST_LSB = 12;

  function automatic logic is_null(input logic [FLIT_W-1:0] flit);
    return flit == NULL_FLIT;
  endfunction

endpackage

// File: rtl/ni_fifo_mem.sv
// Injection queue storage: DEPTH x DW register array, one synchronous write port, one async read port.
module ni_fifo_mem #(
  parameter int DW    = 20,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ni_inject_fifo.sv
// NI injection queue: drops null flits, FWFT output to the router, sticky overflow on drops while full.
// Optional NI_INJ_STATS_EN adds saturating acc_cnt/drop_cnt outputs.
module ni_inject_fifo
  import noc_pkg::*;
#(
  parameter int DW    = FLIT_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_valid,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
`ifdef NI_INJ_STATS_EN
  ,
  output logic [15:0]            acc_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          non_null;
  logic          push;
  logic          pop;
  logic          drop;

  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign non_null  = in_valid && (in_data != DW'(NULL_FLIT));
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push      = non_null && (!full || pop);
  assign drop      = non_null && full && !pop;

  ni_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef NI_INJ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push && acc_cnt != 16'hFFFF)  acc_cnt  <= acc_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ni_inject_fifo.sv
// Bench for ni_inject_fifo: queue-based reference model, scoreboard drained by an output monitor.
module tb_ni_inject_fifo;
  localparam int DW    = 20;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
`ifdef NI_INJ_STATS_EN
  logic [15:0]   acc_cnt;
  logic [15:0]   drop_cnt;
`endif

  ni_inject_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
`ifdef NI_INJ_STATS_EN
    ,
    .acc_cnt   (acc_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: exp_q holds flits the router must still see, in order.
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  logic          model_ovf = 1'b0;
  int            model_acc = 0;
  int            model_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented head flit must match the scoreboard front; pop on handshake.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
      end else begin
        chk(out_ready ? "out_data" : "stall_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle: check DUT state against the model, then drive inputs and advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    int pop_m;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(model_cnt));
    chk("out_valid", 32'(out_valid), 32'(model_cnt != 0));
    chk("full", 32'(full), 32'(model_cnt == DEPTH));
    chk("overflow", 32'(overflow), 32'(model_ovf));
`ifdef NI_INJ_STATS_EN
    chk("acc_cnt", 32'(acc_cnt), 32'(model_acc > 65535 ? 65535 : model_acc));
    chk("drop_cnt", 32'(drop_cnt), 32'(model_drop > 65535 ? 65535 : model_drop));
`endif
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    pop_m = (r && model_cnt > 0) ? 1 : 0;
    model_cnt -= pop_m;
    if (v && d != 0) begin
      if (model_cnt < DEPTH) begin
        exp_q.push_back(d);
        model_cnt++;
        model_acc++;
      end else begin
        model_ovf = 1'b1;
        model_drop++;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 20'h3AAAA;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    model_ovf = 1'b0;
    model_acc = 0;
    model_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_flit();
    logic [DW-1:0] f;
    f = DW'($urandom);
    if (f == '0) f = 20'h00001;
    return f;
  endfunction

  initial begin
    // 1: reset, then first flit visible one cycle after its push edge
    #3;
    do_reset();
    cycle(1'b1, 20'h30010, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    // 2: null filter
    cycle(1'b1, 20'h00000, 1'b0);
    cycle(1'b1, 20'h30010, 1'b0);
    cycle(1'b1, 20'h00000, 1'b0);
    cycle(1'b1, 20'h30020, 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("null_count", 32'(count), 32'd2);
    chk("null_head", 32'(out_data), 32'h30010);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    // 3: overflow with 9 pushes, no pops
    for (int i = 0; i < 9; i++) cycle(1'b1, 20'h31000 + DW'(i + 1), 1'b0);
    cycle(1'b0, '0, 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    // 4: full + push + pop in the same cycle
    cycle(1'b1, 20'h33423, 1'b1);
    cycle(1'b0, '0, 1'b0);
    chk("fullpp_count", 32'(count), 32'd8);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    // 5: backpressure with alternating ready
    cycle(1'b1, 20'h31011, 1'b0);
    cycle(1'b1, 20'h31021, 1'b1);
    cycle(1'b1, 20'h32012, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, (i % 2) == 0);
    // 6: wrap, continuous push/pop of 3*DEPTH flits
    do_reset();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cycle(1'b1, rnd_flit(), 1'b1);
      chk("wrap_count_le1", 32'(count <= 1), 32'd1);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
`ifdef NI_INJ_STATS_EN
    chk("wrap_acc", 32'(acc_cnt), 32'd24);
    chk("wrap_drop", 32'(drop_cnt), 32'd0);
`endif
    // Randomised traffic with nulls, drops and random backpressure
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? '0 : rnd_flit();
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0);
    end
    // Mid-stream reset, then random traffic again
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 1) == 1, rnd_flit(), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(1'b0, '0, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
